// File: rtl/quiz_pkg.sv
// Shared types and constants for the quiz round controller.
package quiz_pkg;

    localparam int DATA_W = 4;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SPIN,
        S_LATCH,
        S_LOAD,
        S_ASK,
        S_RESULT,
        S_DONE
    } state_t;

    localparam logic [1:0] LCG_LATCH = 2'd0;
    localparam logic [1:0] LCG_SPIN  = 2'd1;
    localparam logic [1:0] LCG_HOLD  = 2'd2;

    function automatic logic [DATA_W-1:0] sat_inc(input logic [DATA_W-1:0] v);
        return (v == {DATA_W{1'b1}}) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/quiz_timer.sv
// Answer-window countdown: loads the limit, counts down on tick, flags the final tick.
module quiz_timer
    import quiz_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [DATA_W-1:0] limit_i,
    input  logic              tick_i,
    output logic [DATA_W-1:0] time_left_o,
    output logic              expire_o
);

    logic [DATA_W-1:0] time_left_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            time_left_q <= '0;
        end else if (load_i) begin
            time_left_q <= limit_i;
        end else if (tick_i && time_left_q != '0) begin
            time_left_q <= time_left_q - 1'b1;
        end
    end

    // Combinational so the FSM can leave ASK on the same edge the count hits 0.
    assign expire_o    = tick_i && (time_left_q == DATA_W'(1));
    assign time_left_o = time_left_q;

endmodule

// File: rtl/quiz_round_ctrl.sv
// Quiz game controller: sequences LCG spin/latch, asks questions, scores answers.
module quiz_round_ctrl
    import quiz_pkg::*;
#(
    parameter int ROUNDS     = 8,
    parameter int TIME_LIMIT = 9
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_btn,
    input  logic              submit_btn,
    input  logic [DATA_W-1:0] answer_in,
    input  logic              tick,
    input  logic [DATA_W-1:0] rand_in,
    output logic [1:0]        lcg_state,
    output logic [DATA_W-1:0] question,
    output logic              show_q,
    output logic [DATA_W-1:0] time_left,
    output logic [DATA_W-1:0] score,
    output logic [DATA_W-1:0] round,
    output logic              correct,
    output logic              wrong,
    output logic              done
);

    localparam logic [DATA_W-1:0] ROUNDS_V = DATA_W'(ROUNDS);
    localparam logic [DATA_W-1:0] LIMIT_V  = DATA_W'(TIME_LIMIT);

    state_t            state_q;
    logic [1:0]        lcg_q;
    logic [DATA_W-1:0] question_q, score_q, round_q;
    logic              show_q_q, correct_q, wrong_q, done_q;
    logic              expire, verdict_ok;

    quiz_timer u_timer (
        .clk        (clk),
        .rst        (rst),
        .load_i     (state_q == S_LOAD),
        .limit_i    (LIMIT_V),
        .tick_i     (tick && state_q == S_ASK),
        .time_left_o(time_left),
        .expire_o   (expire)
    );

    // A submit in the same cycle as the final tick is still judged on the answer.
    assign verdict_ok = submit_btn && (answer_in == question_q);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            lcg_q      <= LCG_HOLD;
            question_q <= '0;
            score_q    <= '0;
            round_q    <= '0;
            show_q_q   <= 1'b0;
            correct_q  <= 1'b0;
            wrong_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            correct_q <= 1'b0;
            wrong_q   <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start_btn) begin
                        score_q <= '0;
                        round_q <= '0;
                        done_q  <= 1'b0;
                        lcg_q   <= LCG_SPIN;
                        state_q <= S_SPIN;
                    end
                end
                S_SPIN: begin
                    if (tick) begin
                        lcg_q   <= LCG_LATCH;
                        state_q <= S_LATCH;
                    end
                end
                S_LATCH: begin
                    lcg_q   <= LCG_HOLD;
                    state_q <= S_LOAD;
                end
                S_LOAD: begin
                    question_q <= rand_in;
                    show_q_q   <= 1'b1;
                    state_q    <= S_ASK;
                end
                S_ASK: begin
                    if (submit_btn || expire) begin
                        correct_q <= verdict_ok;
                        wrong_q   <= !verdict_ok;
                        if (verdict_ok) score_q <= sat_inc(score_q);
                        round_q  <= round_q + 1'b1;
                        show_q_q <= 1'b0;
                        state_q  <= S_RESULT;
                    end
                end
                S_RESULT: begin
                    if (round_q == ROUNDS_V) begin
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        lcg_q   <= LCG_SPIN;
                        state_q <= S_SPIN;
                    end
                end
                default: begin
                    lcg_q   <= LCG_HOLD;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign lcg_state = lcg_q;
    assign question  = question_q;
    assign show_q    = show_q_q;
    assign score     = score_q;
    assign round     = round_q;
    assign correct   = correct_q;
    assign wrong     = wrong_q;
    assign done      = done_q;

endmodule

// File: tb/tb_quiz_round_ctrl.sv
// Bench for quiz_round_ctrl: scripted and random games against a round-level score model.
module tb_quiz_round_ctrl;

    localparam int NR = 3;
    localparam int TL = 9;

    logic       clk = 1'b0;
    logic       rst, start_btn, submit_btn, tick;
    logic [3:0] answer_in, rand_in;
    logic [1:0] lcg_state;
    logic [3:0] question, time_left, score, round;
    logic       show_q, correct, wrong, done;

    int errors = 0;
    int checks = 0;

    // Model: game-level bookkeeping only
    int         m_score, m_round;
    logic [3:0] m_q;

    quiz_round_ctrl #(.ROUNDS(NR), .TIME_LIMIT(TL)) dut (
        .clk(clk), .rst(rst), .start_btn(start_btn), .submit_btn(submit_btn),
        .answer_in(answer_in), .tick(tick), .rand_in(rand_in),
        .lcg_state(lcg_state), .question(question), .show_q(show_q),
        .time_left(time_left), .score(score), .round(round),
        .correct(correct), .wrong(wrong), .done(done)
    );

    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start();
        start_btn = 1'b1;
        cyc();
        start_btn = 1'b0;
        m_score = 0;
        m_round = 0;
    endtask

    // One question from SPIN to the cycle after RESULT.
    // mode: 0 correct submit, 1 wrong submit, 2 timeout, 3 correct submit on the final tick
    task automatic play_round(input int wait_n, input logic [3:0] r, input int mode, input int k);
        logic [3:0] ans;
        logic       exp_ok;
        int         tl, nt;
        checks++;
        if (lcg_state !== 2'd1) begin errors++; $display("FAIL spin_entry lcg got %0d want 1", lcg_state); end
        for (int i = 0; i < wait_n; i++) begin
            start_btn  = (i == 0);
            submit_btn = (i == 1);
            answer_in  = 4'h0;
            cyc();
            start_btn  = 1'b0;
            submit_btn = 1'b0;
            checks++;
            if (lcg_state !== 2'd1 || correct !== 1'b0 || wrong !== 1'b0 || score !== 4'(m_score)) begin
                errors++;
                $display("FAIL spin_wait lcg=%0d c=%0d w=%0d score=%0d want lcg=1 c=0 w=0 score=%0d",
                         lcg_state, correct, wrong, score, m_score);
            end
        end
        rand_in = r;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        checks++;
        if (lcg_state !== 2'd0) begin errors++; $display("FAIL latch_lcg got %0d want 0", lcg_state); end
        cyc();
        checks++;
        if (lcg_state !== 2'd2 || show_q !== 1'b0) begin
            errors++; $display("FAIL load lcg=%0d show_q=%0d want 2/0", lcg_state, show_q);
        end
        cyc();
        rand_in = $urandom_range(0, 15);
        m_q = r;
        checks++;
        if (show_q !== 1'b1 || question !== r || time_left !== 4'(TL) || lcg_state !== 2'd2) begin
            errors++;
            $display("FAIL ask_entry show_q=%0d q=%h tl=%0d lcg=%0d want 1/%h/%0d/2",
                     show_q, question, time_left, lcg_state, r, TL);
        end
        tl = TL;
        nt = (mode == 2) ? TL - 1 : (mode == 3) ? TL - 1 : k;
        for (int i = 0; i < nt; i++) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            tl--;
            checks++;
            if (time_left !== 4'(tl) || show_q !== 1'b1 || correct !== 1'b0 || wrong !== 1'b0) begin
                errors++;
                $display("FAIL countdown tl=%0d show_q=%0d c=%0d w=%0d want tl=%0d show_q=1", time_left, show_q, correct, wrong, tl);
            end
        end
        if (mode == 2) begin
            tick = 1'b1;
            cyc();
            tick = 1'b0;
            exp_ok = 1'b0;
            checks++;
            if (time_left !== 4'd0) begin errors++; $display("FAIL timeout_tl got %0d want 0", time_left); end
        end else begin
            ans = (mode == 1) ? (r ^ 4'h5) : r;
            answer_in  = ans;
            submit_btn = 1'b1;
            tick       = (mode == 3);
            cyc();
            submit_btn = 1'b0;
            tick       = 1'b0;
            answer_in  = 4'($urandom_range(0, 15));
            exp_ok = (mode != 1);
        end
        if (exp_ok) m_score = (m_score >= 15) ? 15 : m_score + 1;
        m_round++;
        checks++;
        if (correct !== exp_ok || wrong !== !exp_ok) begin
            errors++; $display("FAIL verdict mode=%0d c=%0d w=%0d want c=%0d", mode, correct, wrong, exp_ok);
        end
        checks++;
        if (score !== 4'(m_score) || round !== 4'(m_round) || show_q !== 1'b0) begin
            errors++;
            $display("FAIL result score=%0d round=%0d show_q=%0d want %0d/%0d/0", score, round, show_q, m_score, m_round);
        end
        cyc();
        checks++;
        if (correct !== 1'b0 || wrong !== 1'b0) begin
            errors++; $display("FAIL verdict_width c=%0d w=%0d want 0/0", correct, wrong);
        end
        checks++;
        if (m_round == NR) begin
            if (done !== 1'b1 || lcg_state !== 2'd2) begin
                errors++; $display("FAIL game_end done=%0d lcg=%0d want 1/2", done, lcg_state);
            end
        end else if (done !== 1'b0 || lcg_state !== 2'd1) begin
            errors++; $display("FAIL next_round done=%0d lcg=%0d want 0/1", done, lcg_state);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; start_btn = 1'b1; submit_btn = 1'b1; tick = 1'b1;
        answer_in = 4'h0; rand_in = 4'h0;
        cyc();
        cyc();
        rst = 1'b0; start_btn = 1'b0; submit_btn = 1'b0; tick = 1'b0;
        checks++;
        if (lcg_state !== 2'd2 || question !== 4'd0 || time_left !== 4'd0 || score !== 4'd0 || round !== 4'd0 ||
            show_q !== 1'b0 || correct !== 1'b0 || wrong !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset lcg=%0d q=%0d tl=%0d s=%0d r=%0d sq=%0d c=%0d w=%0d d=%0d",
                     lcg_state, question, time_left, score, round, show_q, correct, wrong, done);
        end
        tick = 1'b1; submit_btn = 1'b1;
        cyc();
        cyc();
        tick = 1'b0; submit_btn = 1'b0;
        checks++;
        if (lcg_state !== 2'd2 || correct !== 1'b0 || wrong !== 1'b0) begin
            errors++; $display("FAIL idle_hold lcg=%0d c=%0d w=%0d want 2/0/0", lcg_state, correct, wrong);
        end
    endtask

    task automatic test_first_question();
        pulse_start();
        play_round(2, 4'hA, 0, 3);
    endtask

    task automatic test_timeout();
        play_round(3, 4'h7, 2, 0);
    endtask

    task automatic test_submit_tick_race();
        play_round(2, 4'h3, 3, 0);
    endtask

    task automatic test_done_restart();
        for (int i = 0; i < 3; i++) begin
            tick = 1'b1; submit_btn = 1'b1; answer_in = m_q; rand_in = ~m_q;
            cyc();
        end
        tick = 1'b0; submit_btn = 1'b0;
        checks++;
        if (done !== 1'b1 || score !== 4'(m_score) || round !== 4'(NR) || question !== m_q ||
            correct !== 1'b0 || wrong !== 1'b0) begin
            errors++;
            $display("FAIL done_hold d=%0d s=%0d r=%0d q=%h want 1/%0d/%0d/%h", done, score, round, question, m_score, NR, m_q);
        end
        pulse_start();
        checks++;
        if (done !== 1'b0 || score !== 4'd0 || round !== 4'd0 || lcg_state !== 2'd1) begin
            errors++;
            $display("FAIL restart d=%0d s=%0d r=%0d lcg=%0d want 0/0/0/1", done, score, round, lcg_state);
        end
    endtask

    task automatic test_random_games();
        for (int g = 0; g < 3; g++) begin
            for (int r = 0; r < NR; r++) begin
                play_round($urandom_range(2, 5), 4'($urandom_range(0, 15)), $urandom_range(0, 3), $urandom_range(0, TL - 2));
            end
            pulse_start();
        end
    endtask

    task automatic test_reset_mid_question();
        rand_in = 4'h6;
        tick = 1'b1;
        cyc();
        tick = 1'b0;
        cyc();
        cyc();
        for (int i = 0; i < 4; i++) begin
            tick = 1'b1;
            cyc();
        end
        tick = 1'b0;
        checks++;
        if (time_left !== 4'd5 || show_q !== 1'b1) begin
            errors++; $display("FAIL pre_reset tl=%0d show_q=%0d want 5/1", time_left, show_q);
        end
        rst = 1'b1; submit_btn = 1'b1; start_btn = 1'b1; answer_in = 4'h6;
        cyc();
        rst = 1'b0; submit_btn = 1'b0; start_btn = 1'b0;
        checks++;
        if (lcg_state !== 2'd2 || question !== 4'd0 || time_left !== 4'd0 || score !== 4'd0 || round !== 4'd0 ||
            show_q !== 1'b0 || correct !== 1'b0 || wrong !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL mid_reset lcg=%0d q=%0d tl=%0d s=%0d r=%0d sq=%0d c=%0d w=%0d d=%0d",
                     lcg_state, question, time_left, score, round, show_q, correct, wrong, done);
        end
        cyc();
        checks++;
        if (correct !== 1'b0 || wrong !== 1'b0 || lcg_state !== 2'd2) begin
            errors++; $display("FAIL post_reset c=%0d w=%0d lcg=%0d want 0/0/2", correct, wrong, lcg_state);
        end
    endtask

    initial begin
        m_score = 0; m_round = 0; m_q = 4'h0;
        test_reset();
        test_first_question();
        test_timeout();
        test_submit_tick_race();
        test_done_restart();
        test_random_games();
        test_reset_mid_question();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/quiz_round_ctrl.md
QUIZ_ROUND_CTRL -- requirements
Module: quiz_round_ctrl

Interface
REQ-001 The block SHALL have parameter ROUNDS, default 8, giving the questions per game (range 1..15).
REQ-002 The block SHALL have parameter TIME_LIMIT, default 9, giving the answer window in ticks (range 1..15).
REQ-003 clk  input  1  single system clock; all logic on rising edge.
REQ-004 rst  input  1  synchronous, active-high reset.
REQ-005 start_btn  input  1  debounced one-cycle pulse; starts or restarts a game.
REQ-006 submit_btn  input  1  debounced one-cycle pulse; commits answer_in.
REQ-007 answer_in  input  4  player answer from switches.
REQ-008 tick  input  1  one-cycle timebase pulse (nominally 1 Hz).
REQ-009 rand_in  input  4  latched random number from the LCG generator.
REQ-010 lcg_state  output  2  LCG command: 2'd1 spin, 2'd0 latch, 2'd2 hold.
REQ-011 question  output  4  current question value.
REQ-012 show_q  output  1  high while a question is open.
REQ-013 time_left  output  4  remaining ticks for the open question.
REQ-014 score  output  4  correct answers this game.
REQ-015 round  output  4  questions completed this game.
REQ-016 correct, wrong  output  1 each  one-cycle verdict pulses.
REQ-017 done  output  1  high while the game is over.

Function
REQ-018 The FSM SHALL have the states IDLE, SPIN, LATCH, LOAD, ASK, RESULT and DONE.
REQ-019 In IDLE, lcg_state SHALL be 2'd2; on start_btn, score and round SHALL clear and the FSM SHALL go to SPIN.
REQ-020 In SPIN, lcg_state SHALL be 2'd1; the FSM SHALL stay in SPIN for at least one cycle and leave on the first tick seen in SPIN, going to LATCH.
REQ-021 In LATCH, lcg_state SHALL be 2'd0 for exactly one cycle, then the FSM SHALL go to LOAD.
REQ-022 In LOAD (lcg_state 2'd2), question SHALL capture rand_in, time_left SHALL load TIME_LIMIT, and the FSM SHALL go to ASK.
REQ-023 In ASK, show_q SHALL be 1 and each tick SHALL decrement time_left.
REQ-024 In ASK, submit_btn SHALL go to RESULT with verdict = (answer_in == question).
REQ-025 In ASK, a tick while time_left == 1 SHALL set time_left to 0 and go to RESULT with verdict wrong.
REQ-026 If submit_btn and the final tick arrive in the same cycle, submit SHALL win and be judged on answer_in.
REQ-027 In RESULT, exactly one of correct or wrong SHALL pulse for one cycle.
REQ-028 In RESULT, score SHALL increment if the answer is correct, saturating at 15.
REQ-029 In RESULT, round SHALL increment; if the new round equals ROUNDS the FSM SHALL go to DONE, otherwise to SPIN.
REQ-030 In DONE, done SHALL be 1 and score, round and question SHALL hold.
REQ-031 In DONE, start_btn SHALL clear score and round and go to SPIN.
REQ-032 start_btn SHALL be ignored in SPIN through RESULT.
REQ-033 submit_btn SHALL be ignored outside ASK.
REQ-034 tick SHALL be ignored outside SPIN and ASK.
REQ-035 All outputs SHALL be registered.
REQ-036 Latency from start_btn to show_q SHALL be 1 (SPIN entry) + N cycles to the first tick + 1 (LATCH) + 1 (LOAD).

Reset
REQ-037 With rst high at a clock edge, on the next cycle the FSM SHALL be IDLE with lcg_state 2'd2 and question, time_left, score and round all 0.
REQ-038 On that same reset, show_q, correct, wrong and done SHALL all be 0.
REQ-039 rst SHALL override every other input, including mid-question and in the same cycle as start_btn or submit_btn.

Structure
REQ-040 Package quiz_pkg SHALL hold the FSM state enum, the LCG command constants (LCG_SPIN, LCG_LATCH, LCG_HOLD) and the 4-bit data width constant.
REQ-041 Sub-module quiz_timer SHALL implement the time_left countdown: load, decrement on tick, expire flag.
REQ-042 The FSM, score and round logic SHALL live in quiz_round_ctrl; total RTL SHALL be about 150-250 lines.

Verification
REQ-043 Reset, then start_btn, tick 3 cycles later, rand_in=4'hA -> lcg_state sequence 2,1,1,1,0,2; question=4'hA; show_q=1; time_left=9.
REQ-044 In ASK, answer_in=4'hA and submit_btn -> correct pulses for 1 cycle; score=1; round=1; FSM returns to SPIN.
REQ-045 In ASK, 9 ticks with no submit -> time_left goes 9..0; wrong pulses; score unchanged; round increments.
REQ-046 time_left=1, with submit_btn and tick in the same cycle and answer_in==question -> correct (not wrong).
REQ-047 ROUNDS=2, two correct answers -> done=1, score=2, round=2; a later start_btn -> score=0, round=0, SPIN.
REQ-048 rst asserted in ASK with time_left=5 -> next cycle IDLE, all outputs 0, lcg_state=2; a submit_btn in the rst cycle produces no verdict pulse.
